// File: rtl/bft_pkg.sv
// Shared definitions for the butterfly-fat-tree network: direction codes and
// packet field index helpers for the {valid, dest addr, payload} layout.
package bft_pkg;

  typedef enum logic [1:0] {
    VOID  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2,
    UP    = 2'd3
  } dir_t;

  function automatic int addr_w(input int num_leaves);
    return $clog2(num_leaves);
  endfunction

  function automatic int pkt_vld_bit(input int p_sz);
    return p_sz - 1;
  endfunction

  function automatic int pkt_addr_hi(input int p_sz);
    return p_sz - 2;
  endfunction

  function automatic int pkt_addr_lo(input int payload_sz);
    return payload_sz;
  endfunction

  function automatic int pkt_pl_hi(input int payload_sz);
    return payload_sz - 1;
  endfunction

endpackage

// File: rtl/bft_leaf_port_if.sv
// Client/network bundle for bft_leaf_port. Stats signals exist only when
// LEAF_STATS_EN is defined.
interface bft_leaf_port_if #(
  parameter int AW  = 8,
  parameter int PW  = 43,
  parameter int PSZ = 1 + AW + PW
);
  logic [PSZ-1:0] bus_i;
  logic [PSZ-1:0] bus_o;
  logic [AW-1:0]  tx_addr;
  logic [PW-1:0]  tx_payload;
  logic           tx_valid;
  logic           tx_ready;
  logic [PW-1:0]  rx_payload;
  logic           rx_valid;
  logic           rx_ready;
`ifdef LEAF_STATS_EN
  logic [15:0]    stat_tx;
  logic [15:0]    stat_rx;
  logic [15:0]    stat_bounce;
`endif

  modport slave (
    input  bus_i, tx_addr, tx_payload, tx_valid, rx_ready,
    output bus_o, tx_ready, rx_payload, rx_valid
`ifdef LEAF_STATS_EN
    , output stat_tx, stat_rx, stat_bounce
`endif
  );

  modport master (
    output bus_i, tx_addr, tx_payload, tx_valid, rx_ready,
    input  bus_o, tx_ready, rx_payload, rx_valid
`ifdef LEAF_STATS_EN
    , input stat_tx, stat_rx, stat_bounce
`endif
  );

endinterface

// File: rtl/bft_sync_fifo.sv
// Single-clock FIFO; pointers carry one extra wrap bit to tell full from empty.
module bft_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);
  localparam int IW = $clog2(DEPTH);

  logic [IW:0]                 wr_ptr, rd_ptr;
  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic                        do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[IW] != rd_ptr[IW]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
  assign head    = mem[rd_ptr[IW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (IW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (IW+1)'(1);
    end
  end

  // Storage is left unreset; consumers must gate head with empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[IW-1:0]] <= din;
  end

endmodule

// File: rtl/bft_leaf_port.sv
// Leaf endpoint of the BFT deflection network: TX queue injection, RX delivery,
// and bounce of any arrival it cannot keep. LEAF_STATS_EN adds saturating counters.
module bft_leaf_port
  import bft_pkg::*;
#(
  parameter int num_leaves = 256,
  parameter int payload_sz = 43,
  parameter int addr       = 0,
  parameter int p_sz       = 1 + $clog2(num_leaves) + payload_sz,
  parameter int TX_DEPTH   = 4,
  parameter int RX_DEPTH   = 4
) (
  input  logic           clk,
  input  logic           reset,
  bft_leaf_port_if.slave port
);
  localparam int AW      = addr_w(num_leaves);
  localparam int VLD     = pkt_vld_bit(p_sz);
  localparam int ADDR_HI = pkt_addr_hi(p_sz);
  localparam int ADDR_LO = pkt_addr_lo(payload_sz);
  localparam int PL_HI   = pkt_pl_hi(payload_sz);
  localparam logic [AW-1:0] MY_ADDR = AW'(addr);

  logic                  arr_v, accept, bounce;
  logic [AW-1:0]         arr_dest;
  logic                  tx_full, tx_empty, tx_pop;
  logic [p_sz-1:0]       tx_head;
  logic                  rx_full, rx_empty, rx_pop;
  logic [payload_sz-1:0] rx_head;
  logic [p_sz-1:0]       bus_nxt;

  assign arr_v    = port.bus_i[VLD];
  assign arr_dest = port.bus_i[ADDR_HI:ADDR_LO];
  // rx_full is registered occupancy, so a same-cycle pop never admits an arrival.
  assign accept   = arr_v && (arr_dest == MY_ADDR) && !rx_full;
  assign bounce   = arr_v && !accept;
  assign tx_pop   = !bounce && !tx_empty;
  assign rx_pop   = port.rx_ready && !rx_empty;

  bft_sync_fifo #(.WIDTH(p_sz), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (port.tx_valid),
    .pop   (tx_pop),
    .din   ({1'b1, port.tx_addr, port.tx_payload}),
    .head  (tx_head),
    .full  (tx_full),
    .empty (tx_empty)
  );

  bft_sync_fifo #(.WIDTH(payload_sz), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .pop   (rx_pop),
    .din   (port.bus_i[PL_HI:0]),
    .head  (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

  assign port.tx_ready   = !tx_full;
  assign port.rx_valid   = !rx_empty;
  assign port.rx_payload = rx_empty ? '0 : rx_head;

  always_comb begin
    bus_nxt = '0;
    if (bounce)      bus_nxt = port.bus_i;
    else if (tx_pop) bus_nxt = tx_head;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) port.bus_o <= '0;
    else       port.bus_o <= bus_nxt;
  end

`ifdef LEAF_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      port.stat_tx     <= '0;
      port.stat_rx     <= '0;
      port.stat_bounce <= '0;
    end else begin
      if (tx_pop && port.stat_tx != 16'hFFFF)     port.stat_tx     <= port.stat_tx + 16'd1;
      if (accept && port.stat_rx != 16'hFFFF)     port.stat_rx     <= port.stat_rx + 16'd1;
      if (bounce && port.stat_bounce != 16'hFFFF) port.stat_bounce <= port.stat_bounce + 16'd1;
    end
  end
`else
  // Stats counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_bft_leaf_port.sv
// Queue-based reference model of the leaf port driven by directed and random traffic.
module tb_bft_leaf_port;
  localparam int NL  = 256;
  localparam int PL  = 43;
  localparam int AW  = 8;
  localparam int PSZ = 52;
  localparam int TXD = 4;
  localparam int RXD = 4;
  localparam logic [AW-1:0] ADDR  = 8'd0;
  localparam logic [AW-1:0] OTHER = 8'd1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bft_leaf_port_if #(.AW(AW), .PW(PL), .PSZ(PSZ)) bif ();

  bft_leaf_port #(
    .num_leaves(NL), .payload_sz(PL), .addr(0), .p_sz(PSZ),
    .TX_DEPTH(TXD), .RX_DEPTH(RXD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .port  (bif.slave)
  );

  int total = 0;
  int bad = 0;

  logic [PSZ-1:0] txq[$];
  logic [PL-1:0]  rxq[$];
  logic [PSZ-1:0] exp_bus = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [PSZ-1:0] pkt(input logic [AW-1:0] a, input logic [PL-1:0] p);
    return {1'b1, a, p};
  endfunction

  task automatic compare_all();
    chk("bus_o", 64'(bif.bus_o), 64'(exp_bus));
    chk("tx_ready", 64'(bif.tx_ready), 64'(txq.size() < TXD));
    chk("rx_valid", 64'(bif.rx_valid), 64'(rxq.size() > 0));
    chk("rx_payload", 64'(bif.rx_payload), (rxq.size() > 0) ? 64'(rxq[0]) : 64'd0);
  endtask

  // Drive one cycle of inputs, advance the model, then check after the edge.
  task automatic step(input logic [PSZ-1:0] bi, input logic tv, input logic [AW-1:0] ta,
                      input logic [PL-1:0] tp, input logic rr);
    bit tx_fire, rx_fire, bnc;
    logic [PSZ-1:0] nb;
    bif.bus_i      = bi;
    bif.tx_valid   = tv;
    bif.tx_addr    = ta;
    bif.tx_payload = tp;
    bif.rx_ready   = rr;
    tx_fire = tv && (txq.size() < TXD);
    rx_fire = rr && (rxq.size() > 0);
    bnc = 1'b0;
    if (bi[PSZ-1]) bnc = !((bi[PSZ-2 -: AW] == ADDR) && (rxq.size() < RXD));
    nb = '0;
    if (bnc) nb = bi;
    else if (txq.size() > 0) nb = txq.pop_front();
    if (rx_fire) void'(rxq.pop_front());
    if (bi[PSZ-1] && !bnc) rxq.push_back(bi[PL-1:0]);
    if (tx_fire) txq.push_back(pkt(ta, tp));
    @(posedge clk);
    #1;
    exp_bus = nb;
    compare_all();
  endtask

  task automatic idle(input logic rr);
    step('0, 1'b0, '0, '0, rr);
  endtask

  initial begin
    logic [AW-1:0]  d;
    logic [PSZ-1:0] bi;
    bif.bus_i = '0; bif.tx_valid = 1'b0; bif.tx_addr = '0;
    bif.tx_payload = '0; bif.rx_ready = 1'b0;
    #12;
    chk("reset_bus_o", 64'(bif.bus_o), 64'd0);
    chk("reset_tx_ready", 64'(bif.tx_ready), 64'd1);
    chk("reset_rx_valid", 64'(bif.rx_valid), 64'd0);
    chk("reset_rx_payload", 64'(bif.rx_payload), 64'd0);
    reset = 1'b0;

    // Basic inject
    step('0, 1'b1, 8'd5, 43'h1A, 1'b0);
    idle(1'b0);
    chk("inject", 64'(bif.bus_o), 64'({1'b1, 8'd5, 43'h1A}));
    idle(1'b0);
    chk("inject_after", 64'(bif.bus_o), 64'd0);

    // Receive, held until rx_ready
    step(pkt(ADDR, 43'h3), 1'b0, '0, '0, 1'b0);
    chk("rx_valid_lit", 64'(bif.rx_valid), 64'd1);
    chk("rx_payload_lit", 64'(bif.rx_payload), 64'h3);
    idle(1'b0);
    chk("rx_hold", 64'(bif.rx_payload), 64'h3);
    idle(1'b1);
    chk("rx_popped", 64'(bif.rx_valid), 64'd0);

    // Misroute bounce ahead of a queued TX packet
    step('0, 1'b1, 8'd9, 43'h55, 1'b0);
    step(pkt(OTHER, 43'h7), 1'b0, '0, '0, 1'b0);
    chk("bounce_first", 64'(bif.bus_o), 64'({1'b1, 8'd1, 43'h7}));
    idle(1'b0);
    chk("tx_after_bounce", 64'(bif.bus_o), 64'({1'b1, 8'd9, 43'h55}));

    // RX full: fifth arrival bounces, even with a same-cycle pop
    for (int k = 0; k < 4; k++) step(pkt(ADDR, 43'(k + 16)), 1'b0, '0, '0, 1'b0);
    step(pkt(ADDR, 43'h99), 1'b0, '0, '0, 1'b0);
    chk("rx_full_bounce", 64'(bif.bus_o), 64'({1'b1, 8'd0, 43'h99}));
    chk("rx_full_head", 64'(bif.rx_payload), 64'h10);
    step(pkt(ADDR, 43'h9A), 1'b0, '0, '0, 1'b1);
    chk("rx_full_pop_bounce", 64'(bif.bus_o), 64'({1'b1, 8'd0, 43'h9A}));
    chk("rx_full_next_head", 64'(bif.rx_payload), 64'h11);
    for (int k = 0; k < 4; k++) idle(1'b1);

    // TX full under continuous bounces, then in-order drain
    for (int k = 0; k < 4; k++) step(pkt(8'd2, 43'(k)), 1'b1, 8'(k + 32), 43'(k + 100), 1'b0);
    chk("tx_full", 64'(bif.tx_ready), 64'd0);
    step(pkt(8'd2, 43'h5), 1'b1, 8'd40, 43'h200, 1'b0);
    idle(1'b0);
    chk("tx_drain_first", 64'(bif.bus_o), 64'({1'b1, 8'd32, 43'd100}));
    for (int k = 0; k < 4; k++) idle(1'b0);

    // Async reset between edges with both queues non-empty
    step(pkt(ADDR, 43'h44), 1'b1, 8'd7, 43'h1, 1'b0);
    step(pkt(8'd3, 43'h1), 1'b1, 8'd7, 43'h2, 1'b0);
    bif.bus_i = '0; bif.tx_valid = 1'b0; bif.rx_ready = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    chk("areset_bus_o", 64'(bif.bus_o), 64'd0);
    chk("areset_tx_ready", 64'(bif.tx_ready), 64'd1);
    chk("areset_rx_valid", 64'(bif.rx_valid), 64'd0);
    chk("areset_rx_payload", 64'(bif.rx_payload), 64'd0);
    txq.delete();
    rxq.delete();
    exp_bus = '0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    compare_all();

    // Randomized traffic: first phase starves rx_ready to exercise RX-full bounces
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 2))
        0: d = ADDR;
        1: d = OTHER;
        default: d = 8'($urandom());
      endcase
      bi = '0;
      if ($urandom_range(0, 1) == 1) bi = pkt(d, 43'({$urandom(), $urandom()}));
      step(bi,
           (n < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 1),
           8'($urandom()),
           43'({$urandom(), $urandom()}),
           (n < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
    end
    for (int k = 0; k < 8; k++) idle(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
